btn_event_arbiter: RTL
======================

Name: btn_event_arbiter

Overview:
- Front end for all push-buttons on the board. It takes N raw asynchronous button pins and debounces each one.
- It turns each debounced press into exactly one event (single-pulse semantics: a held button yields one event, and a release must come before the next).
- Pending events are queued one bit per button and offered one at a time to the downstream controller over a valid/ready handshake, using round-robin arbitration.

Parameters:
- N_BTN, 4, number of button inputs (2..16)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>=2)
- ID_W, $clog2(N_BTN), width of evt_id (derived, not overridden)

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- btn  input  N_BTN  raw asynchronous button levels, 1 = pressed
- btn_level  output  N_BTN  debounced button levels
- evt_valid  output  1  event offered
- evt_id  output  ID_W  index of the offered button
- evt_ready  input  1  consumer accepts the event this cycle
- overrun  output  N_BTN  one-cycle pulse: press lost because that button's event was still pending

Behaviour:
- Reset (reset=1 at a posedge) clears all state:
  - btn_level=0, evt_valid=0, evt_id=0, overrun=0.
  - Sync flops=0, debounce counters=0, pending=0, RR pointer=0, FSM=IDLE.
- Per-button synchronizer: 2 flops, s1 then s2. E0 is the first posedge at which s1 samples the new level.
- Debounce:
  - The counter increments on every edge where s2 != btn_level, and clears on any edge where s2 == btn_level.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, btn_level <= s2 and the counter clears.
  - A clean press therefore sets btn_level at E(1+DEBOUNCE_CYCLES).
- Press pulse:
  - press[i] is registered, high for exactly one cycle, at edge E(2+D) after btn_level[i] rises.
  - A falling btn_level produces nothing.
- Pending:
  - pending[i] is set by press[i] and cleared on an accepted handshake for id i.
  - Simultaneous clear of i and a new press[i]: pending[i] stays 1 (the new event is kept).
  - press[i] while pending[i]=1 and not being cleared: the press is dropped, and overrun[i]=1 for the next cycle only.
- FSM, 2 states:
  - IDLE: if any pending bit is set, choose the first set bit searching upward from ptr, wrapping at N_BTN-1 to 0. Register evt_id=that index and evt_valid=1, then go to OFFER. Otherwise stay, with evt_valid=0.
  - OFFER: evt_valid and evt_id are held stable until evt_ready=1.
  - On handshake (evt_valid & evt_ready at a posedge): pending[evt_id] cleared, ptr <= (evt_id+1) mod N_BTN, evt_valid <= 0, go to IDLE.
  - There is always one bubble cycle between consecutive events.
- Latency, clean press, no contention: pending at E(3+D), evt_valid high from E(4+D).
- evt_ready while evt_valid=0 is ignored.
- Reset mid-operation:
  - evt_valid drops at the reset edge and the pending event is discarded.
  - A button held through reset has btn_level=0 afterwards, so it produces exactly one new event after debounce.
- Arithmetic:
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
  - ptr wraps explicitly to 0 when N_BTN is not a power of two.

Decomposition:
- Package btn_pkg holds:
  - the FSM state enum (IDLE, OFFER);
  - the default constants N_BTN_DEF and DEBOUNCE_DEF;
  - the round-robin next-index function.
- Sub-module btn_debounce_pulse, instantiated N_BTN times via generate:
  - contains sync, debounce counter, btn_level and press pulse;
  - ports: clk, reset, btn_raw, level, press.
- The top level holds pending, the RR pointer, the FSM and the overrun logic.

Test Plan (N_BTN=4, DEBOUNCE_CYCLES=4, E0 = first edge s1 sees the steady level):
1. Bounce rejection:
   - Stimulus: btn[0] toggles every 2 cycles for 12 cycles, then steady 1, evt_ready=1.
   - Required: btn_level[0] rises at E5; exactly one event, evt_valid high only at E8 (one cycle), evt_id=0.
2. Held button:
   - Stimulus: btn[3] held for 200 cycles, evt_ready=1.
   - Required: exactly one event, id=3.
   - Then release for 10 cycles and press again: exactly one more event, id=3, with ptr then 0.
3. Round-robin:
   - Stimulus: btn[1], btn[2], btn[3] rise in the same cycle, evt_ready=1.
   - Required: events id 1, 2, 3 in that order, each valid for 1 cycle with 1 idle cycle between.
   - Then btn[0] and btn[3] pressed together: order is 0, then 3.
4. Backpressure and overrun:
   - Stimulus: evt_ready=0, press btn[2].
   - Required: evt_valid=1 with evt_id=2 held for 30 cycles.
   - Release and re-press btn[2]: overrun[2] pulses for exactly 1 cycle.
   - Then evt_ready=1: exactly one event, id=2, and no further events.
5. Reset mid-offer:
   - Stimulus: reset=1 for 1 cycle while evt_valid=1 and btn[1] is held.
   - Required: evt_valid=0 from the reset edge; one fresh id=1 event at E8 relative to the first post-reset sample.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button event front end:
//   - arb_state_t  : two-state offer FSM encoding (IDLE, OFFER)
//   - N_BTN_DEF    : default number of buttons
//   - DEBOUNCE_DEF : default debounce length in clock cycles
//   - rr_next()    : round-robin successor of an index, wrapping at n-1 -> 0
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int N_BTN_DEF    = 4;
    localparam int DEBOUNCE_DEF = 16;

    // Successor index for the round-robin pointer. The wrap is explicit so
    // non-power-of-two button counts never leave the valid index range.
    function automatic int unsigned rr_next(input int unsigned idx,
                                            input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
// One button lane: two-flop synchronizer, debounce counter, debounced level
// and a single-cycle press pulse on each rising debounced level.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   btn_raw in   raw asynchronous button level (1 = pressed)
//   level   out  debounced level
//   press   out  one-cycle pulse, one cycle after level rises
// -----------------------------------------------------------------------------
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the edge where it would otherwise reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn_raw;
            s2      <= s1;
            level_q <= level;
            // Only rising edges of the debounced level create an event.
            press   <= level & ~level_q;

            // Any agreement with the current level restarts the run, so a
            // bouncing input never accumulates toward a level change.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
// Debounces N_BTN push-buttons, turns every debounced press into one pending
// event bit, and offers pending events one at a time over valid/ready using
// round-robin arbitration.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   btn        in   [N_BTN]  raw button levels, 1 = pressed
//   btn_level  out  [N_BTN]  debounced button levels
//   evt_valid  out           event offered
//   evt_id     out  [ID_W]   index of the offered button
//   evt_ready  in            consumer accepts the offered event
//   overrun    out  [N_BTN]  one-cycle pulse: press lost, event still pending
// -----------------------------------------------------------------------------
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter  int N_BTN           = N_BTN_DEF,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    localparam int ID_W            = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] overrun
);

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] clr;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic             hs;
    int               cand;
    arb_state_t       state;

    // -------------------------------------------------------------------------
    // Per-button debounce and press detection
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_debounce_pulse #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn[i]),
            .level   (btn_level[i]),
            .press   (press[i])
        );
    end

    // -------------------------------------------------------------------------
    // Handshake and round-robin pick
    // -------------------------------------------------------------------------
    assign hs = evt_valid & evt_ready;

    always_comb begin
        clr = '0;
        if (hs) clr[evt_id] = 1'b1;
    end

    // Scan downward so the last hit written is the closest set bit at or
    // above ptr (modulo N_BTN).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            cand = 32'(ptr) + k;
            if (cand >= N_BTN) cand = cand - N_BTN;
            if (pending[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending bits, overrun pulses and the offer FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            ptr       <= '0;
            pending   <= '0;
            overrun   <= '0;
        end else begin
            // A press landing on the cycle its old event is accepted survives
            // as a fresh pending event; otherwise a press on a pending bit is lost.
            pending <= (pending & ~clr) | press;
            overrun <= press & pending & ~clr;

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        evt_id    <= pick_idx;
                        evt_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    // Returning to IDLE on accept gives the mandatory bubble.
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        ptr       <= ID_W'(rr_next(32'(evt_id), 32'(N_BTN)));
                        state     <= IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
